// File: rtl/sc_packet_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : sc_packet_fifo_if
// Description : Write/read handshake and status bundle for sc_packet_fifo.
// Revision    : 1.0 - initial release
// ============================================================================
interface sc_packet_fifo_if #(
    parameter int DEPTH = 512,
    parameter int WIDTH = 512
);
    localparam int c_CW = $clog2(DEPTH) + 1;

    logic             write;
    logic [WIDTH-1:0] din;
    logic             din_last;
    logic             din_drop;
    logic             full;
    logic             almost_full;
    logic             prog_full;
    logic             write_ack;
    logic             overflow;
    logic [c_CW-1:0]  din_count;

    logic             read;
    logic [WIDTH-1:0] dout;
    logic             dout_last;
    logic             dout_valid;
    logic             empty;
    logic             almost_empty;
    logic             prog_empty;
    logic             underflow;
    logic [c_CW-1:0]  dout_count;
    logic [c_CW-1:0]  packet_count;

    modport master (
        output write, din, din_last, din_drop, read,
        input  full, almost_full, prog_full, write_ack, overflow, din_count,
        input  dout, dout_last, dout_valid, empty, almost_empty, prog_empty,
        input  underflow, dout_count, packet_count
    );

    modport slave (
        input  write, din, din_last, din_drop, read,
        output full, almost_full, prog_full, write_ack, overflow, din_count,
        output dout, dout_last, dout_valid, empty, almost_empty, prog_empty,
        output underflow, dout_count, packet_count
    );
endinterface
`default_nettype wire

// File: rtl/sc_packet_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sc_packet_fifo
// Description : Single-clock FWFT FIFO with packet commit (din_last) and
//               discard of the uncommitted tail (din_drop).
// Revision    : 1.0 - initial release
// ============================================================================
module sc_packet_fifo #(
    parameter int DEPTH             = 512,
    parameter int WIDTH             = 512,
    parameter bit PACKET_MODE       = 1'b1,
    parameter int PROG_FULL_THRESH  = 508,
    parameter int PROG_EMPTY_THRESH = 10
) (
    input  wire logic       clock,
    input  wire logic       reset,
    sc_packet_fifo_if.slave fifo_if
);
    localparam int              c_AW       = $clog2(DEPTH);
    localparam int              c_PW       = c_AW + 1;
    localparam logic [c_PW-1:0] c_ONE      = c_PW'(1);
    localparam logic [c_PW-1:0] c_DEPTH    = c_PW'(DEPTH);
    localparam logic [c_PW-1:0] c_DEPTH_M1 = c_PW'(DEPTH - 1);
    localparam logic [c_PW-1:0] c_PF       = c_PW'(PROG_FULL_THRESH);
    localparam logic [c_PW-1:0] c_PE       = c_PW'(PROG_EMPTY_THRESH);

    logic [WIDTH:0]    r_mem [DEPTH];
    logic [c_PW-1:0]   r_wr_ptr;
    logic [c_PW-1:0]   r_commit_ptr;
    logic [c_PW-1:0]   r_avail_ptr;
    logic [c_PW-1:0]   r_rd_ptr;
    logic [c_PW-1:0]   r_pkt_cnt;
    logic [WIDTH-1:0]  r_dout;
    logic              r_dout_last;
    logic              r_dout_valid;
    logic              r_full;
    logic              r_almost_full;
    logic              r_prog_full;
    logic              r_write_ack;
    logic              r_overflow;
    logic              r_almost_empty;
    logic              r_prog_empty;
    logic              r_underflow;

    logic              w_drop;
    logic              w_wr_en;
    logic              w_last_in;
    logic              w_commit;
    logic              w_pop;
    logic              w_pop_last;
    logic              w_load;
    logic [c_PW-1:0]   w_wr_nxt;
    logic [c_PW-1:0]   w_commit_nxt;
    logic [c_PW-1:0]   w_rd_nxt;
    logic [c_PW-1:0]   w_din_cnt_nxt;
    logic [c_PW-1:0]   w_dout_cnt_nxt;
    logic [WIDTH:0]    w_rd_word;

    always_comb begin
        w_drop     = PACKET_MODE && fifo_if.din_drop;
        w_wr_en    = fifo_if.write && !r_full && !w_drop;
        w_last_in  = PACKET_MODE ? fifo_if.din_last : 1'b1;
        w_commit   = w_wr_en && w_last_in;
        w_pop      = fifo_if.read && r_dout_valid;
        w_pop_last = w_pop && r_dout_last;

        w_wr_nxt = r_wr_ptr;
        if (w_drop) begin
            w_wr_nxt = r_commit_ptr;
        end else if (w_wr_en) begin
            w_wr_nxt = r_wr_ptr + c_ONE;
        end
        w_commit_nxt   = w_commit ? (r_wr_ptr + c_ONE) : r_commit_ptr;
        w_rd_nxt       = w_pop ? (r_rd_ptr + c_ONE) : r_rd_ptr;
        w_din_cnt_nxt  = w_wr_nxt - w_rd_nxt;
        w_dout_cnt_nxt = w_commit_nxt - w_rd_nxt;

        // The output stage only sees commits one cycle late (r_avail_ptr),
        // which gives the two-edge commit-to-present latency.
        w_load    = (!r_dout_valid || w_pop) && (w_rd_nxt != r_avail_ptr);
        w_rd_word = r_mem[w_rd_nxt[c_AW-1:0]];
    end

    always_ff @(posedge clock) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= {w_last_in, fifo_if.din};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr       <= '0;
            r_commit_ptr   <= '0;
            r_avail_ptr    <= '0;
            r_rd_ptr       <= '0;
            r_pkt_cnt      <= '0;
            r_dout         <= '0;
            r_dout_last    <= 1'b0;
            r_dout_valid   <= 1'b0;
            r_full         <= 1'b0;
            r_almost_full  <= 1'b0;
            r_prog_full    <= 1'b0;
            r_write_ack    <= 1'b0;
            r_overflow     <= 1'b0;
            r_almost_empty <= 1'b1;
            r_prog_empty   <= 1'b1;
            r_underflow    <= 1'b0;
        end else begin
            r_wr_ptr     <= w_wr_nxt;
            r_commit_ptr <= w_commit_nxt;
            r_avail_ptr  <= r_commit_ptr;
            r_rd_ptr     <= w_rd_nxt;

            if (w_commit && !w_pop_last) begin
                r_pkt_cnt <= r_pkt_cnt + c_ONE;
            end else if (w_pop_last && !w_commit) begin
                r_pkt_cnt <= r_pkt_cnt - c_ONE;
            end

            if (w_load) begin
                r_dout       <= w_rd_word[WIDTH-1:0];
                r_dout_last  <= w_rd_word[WIDTH];
                r_dout_valid <= 1'b1;
            end else if (w_pop) begin
                r_dout_valid <= 1'b0;
            end

            r_full         <= (w_din_cnt_nxt == c_DEPTH);
            r_almost_full  <= (w_din_cnt_nxt >= c_DEPTH_M1);
            r_prog_full    <= (w_din_cnt_nxt >= c_PF);
            r_almost_empty <= (w_dout_cnt_nxt <= c_ONE);
            r_prog_empty   <= (w_dout_cnt_nxt <= c_PE);
            r_write_ack    <= w_wr_en;
            r_overflow     <= fifo_if.write && r_full && !w_drop;
            r_underflow    <= fifo_if.read && !r_dout_valid;
        end
    end

    assign fifo_if.full         = r_full;
    assign fifo_if.almost_full  = r_almost_full;
    assign fifo_if.prog_full    = r_prog_full;
    assign fifo_if.write_ack    = r_write_ack;
    assign fifo_if.overflow     = r_overflow;
    assign fifo_if.din_count    = r_wr_ptr - r_rd_ptr;
    assign fifo_if.dout         = r_dout;
    assign fifo_if.dout_last    = r_dout_last;
    assign fifo_if.dout_valid   = r_dout_valid;
    assign fifo_if.empty        = ~r_dout_valid;
    assign fifo_if.almost_empty = r_almost_empty;
    assign fifo_if.prog_empty   = r_prog_empty;
    assign fifo_if.underflow    = r_underflow;
    assign fifo_if.dout_count   = r_commit_ptr - r_rd_ptr;
    assign fifo_if.packet_count = r_pkt_cnt;
endmodule
`default_nettype wire

// File: tb/tb_sc_packet_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_sc_packet_fifo
// Description : Scenario and randomized checks of sc_packet_fifo (packet and
//               plain mode, depth 8) against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sc_packet_fifo;
    logic clk = 1'b0;
    logic rst0, rst1;
    bit   sel;
    always #5 clk = ~clk;

    sc_packet_fifo_if #(.DEPTH(8), .WIDTH(16)) bus0 ();
    sc_packet_fifo_if #(.DEPTH(8), .WIDTH(16)) bus1 ();

    sc_packet_fifo #(.DEPTH(8), .WIDTH(16), .PACKET_MODE(1'b1),
                     .PROG_FULL_THRESH(6), .PROG_EMPTY_THRESH(2))
        u_dut_pkt (.clock(clk), .reset(rst0), .fifo_if(bus0.slave));
    sc_packet_fifo #(.DEPTH(8), .WIDTH(16), .PACKET_MODE(1'b0),
                     .PROG_FULL_THRESH(6), .PROG_EMPTY_THRESH(2))
        u_dut_plain (.clock(clk), .reset(rst1), .fifo_if(bus1.slave));

    logic        obs_full, obs_af, obs_pf, obs_ack, obs_ovf, obs_empty, obs_ae, obs_pe, obs_unf;
    logic        obs_valid, obs_dlast;
    logic [3:0]  obs_din, obs_dc, obs_pc;
    logic [15:0] obs_dout;
    logic [20:0] obs_st;

    always_comb begin
        if (sel) begin
            obs_full = bus1.full; obs_af = bus1.almost_full; obs_pf = bus1.prog_full;
            obs_ack = bus1.write_ack; obs_ovf = bus1.overflow; obs_empty = bus1.empty;
            obs_ae = bus1.almost_empty; obs_pe = bus1.prog_empty; obs_unf = bus1.underflow;
            obs_din = bus1.din_count; obs_dc = bus1.dout_count; obs_pc = bus1.packet_count;
            obs_valid = bus1.dout_valid; obs_dlast = bus1.dout_last; obs_dout = bus1.dout;
        end else begin
            obs_full = bus0.full; obs_af = bus0.almost_full; obs_pf = bus0.prog_full;
            obs_ack = bus0.write_ack; obs_ovf = bus0.overflow; obs_empty = bus0.empty;
            obs_ae = bus0.almost_empty; obs_pe = bus0.prog_empty; obs_unf = bus0.underflow;
            obs_din = bus0.din_count; obs_dc = bus0.dout_count; obs_pc = bus0.packet_count;
            obs_valid = bus0.dout_valid; obs_dlast = bus0.dout_last; obs_dout = bus0.dout;
        end
        obs_st = {obs_full, obs_af, obs_pf, obs_ack, obs_ovf, obs_empty, obs_ae, obs_pe,
                  obs_unf, obs_din, obs_dc, obs_pc};
    end

    // Reference model: uncommitted tail and committed list of words; a committed
    // word may be presented once it is at the head and two edges have passed.
    typedef struct {
        logic [15:0] d;
        logic        l;
        int          ce;
    } ent_t;

    ent_t q_unc[$];
    ent_t q_comm[$];
    int   g_edge;
    bit   m_pmode, m_ack, m_ovf, m_unf, m_valid;
    int   n_checks, n_pass;

    function automatic logic [20:0] exp_st();
        int din, dc, pc;
        din = q_unc.size() + q_comm.size();
        dc  = q_comm.size();
        pc  = 0;
        foreach (q_comm[i]) if (q_comm[i].l) pc++;
        return {din == 8, din >= 7, din >= 6, m_ack, m_ovf, !m_valid, dc <= 1, dc <= 2,
                m_unf, 4'(din), 4'(dc), 4'(pc)};
    endfunction

    task automatic drive(input bit w, input logic [15:0] d, input bit l, input bit dr, input bit r);
        bus0.write = 1'b0; bus0.din = '0; bus0.din_last = 1'b0; bus0.din_drop = 1'b0; bus0.read = 1'b0;
        bus1.write = 1'b0; bus1.din = '0; bus1.din_last = 1'b0; bus1.din_drop = 1'b0; bus1.read = 1'b0;
        if (sel) begin
            bus1.write = w; bus1.din = d; bus1.din_last = l; bus1.din_drop = dr; bus1.read = r;
        end else begin
            bus0.write = w; bus0.din = d; bus0.din_last = l; bus0.din_drop = dr; bus0.read = r;
        end
    endtask

    task automatic apply_reset();
        drive(0, '0, 0, 0, 0);
        rst0 = 1'b1; rst1 = 1'b1;
        @(posedge clk);
        g_edge++;
        q_unc.delete(); q_comm.delete();
        m_ack = 0; m_ovf = 0; m_unf = 0; m_valid = 0;
        #1;
        rst0 = 1'b0; rst1 = 1'b0;
    endtask

    task automatic step(input bit w, input logic [15:0] d, input bit l, input bit dr, input bit r);
        bit   full_pre, drop, acc, pop;
        ent_t e;
        drive(w, d, l, dr, r);
        full_pre = (q_unc.size() + q_comm.size()) == 8;
        drop     = m_pmode && dr;
        acc      = w && !full_pre && !drop;
        pop      = r && m_valid;
        @(posedge clk);
        g_edge++;
        m_ack = acc;
        m_ovf = w && full_pre && !drop;
        m_unf = r && !m_valid;
        if (pop) void'(q_comm.pop_front());
        if (drop) q_unc.delete();
        if (acc) begin
            e.d = d; e.l = m_pmode ? l : 1'b1; e.ce = g_edge;
            q_unc.push_back(e);
            if (e.l) begin
                while (q_unc.size() > 0) begin
                    e = q_unc.pop_front();
                    e.ce = g_edge;
                    q_comm.push_back(e);
                end
            end
        end
        m_valid = (q_comm.size() > 0) && (q_comm[0].ce + 2 <= g_edge);
        #1;
    endtask

    task automatic drain();
        step(0, '0, 0, 1, 0);
        for (int i = 0; i < 24 && q_comm.size() > 0; i++) step(0, '0, 0, 0, m_valid);
        step(0, '0, 0, 0, 0);
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if (obs_st !== 21'b0_0_0_0_0_1_1_1_0_0000_0000_0000)
            $display("FAIL reset_flags: got %b want %b", obs_st, 21'b0_0_0_0_0_1_1_1_0_0000_0000_0000);
        else n_pass++;
        n_checks++;
        if ({obs_dout, obs_dlast} !== 17'h0)
            $display("FAIL reset_dout: got %h want 0", {obs_dout, obs_dlast});
        else n_pass++;
    endtask

    task automatic test_commit_latency();
        for (int i = 0; i < 4; i++) begin
            step(1, 16'hA000 + 16'(i), i == 3, 0, 0);
            n_checks++;
            if (obs_empty !== 1'b1) $display("FAIL latency_empty_w%0d: got %b want 1", i, obs_empty);
            else n_pass++;
        end
        step(0, '0, 0, 0, 0);
        n_checks++;
        if (obs_empty !== 1'b1) $display("FAIL latency_e1: got %b want 1", obs_empty);
        else n_pass++;
        step(0, '0, 0, 0, 0);
        n_checks++;
        if ({obs_empty, obs_dout, obs_dc, obs_pc, obs_din} !== {1'b0, 16'hA000, 4'd4, 4'd1, 4'd4})
            $display("FAIL latency_e2: got %h want %h", {obs_empty, obs_dout, obs_dc, obs_pc, obs_din},
                     {1'b0, 16'hA000, 4'd4, 4'd1, 4'd4});
        else n_pass++;
        n_checks++;
        if (obs_st !== exp_st()) $display("FAIL latency_status: got %b want %b", obs_st, exp_st());
        else n_pass++;
        drain();
    endtask

    task automatic test_drop();
        logic [15:0] d0, d1;
        for (int i = 0; i < 3; i++) step(1, 16'($urandom), 0, 0, 0);
        n_checks++;
        if (obs_din !== 4'd3) $display("FAIL drop_pre_count: got %0d want 3", obs_din);
        else n_pass++;
        step(0, '0, 0, 1, 0);
        n_checks++;
        if ({obs_din, obs_empty, obs_pc} !== {4'd0, 1'b1, 4'd0})
            $display("FAIL drop_after: got %h want %h", {obs_din, obs_empty, obs_pc}, {4'd0, 1'b1, 4'd0});
        else n_pass++;
        d0 = 16'($urandom); d1 = 16'($urandom);
        step(1, d0, 0, 0, 0);
        step(1, d1, 1, 0, 0);
        step(0, '0, 0, 0, 0);
        step(0, '0, 0, 0, 0);
        n_checks++;
        if ({obs_valid, obs_dout, obs_dlast} !== {1'b1, d0, 1'b0})
            $display("FAIL drop_next_w0: got %h want %h", {obs_valid, obs_dout, obs_dlast}, {1'b1, d0, 1'b0});
        else n_pass++;
        step(0, '0, 0, 0, 1);
        n_checks++;
        if ({obs_valid, obs_dout, obs_dlast} !== {1'b1, d1, 1'b1})
            $display("FAIL drop_next_w1: got %h want %h", {obs_valid, obs_dout, obs_dlast}, {1'b1, d1, 1'b1});
        else n_pass++;
        drain();
    endtask

    task automatic test_full();
        for (int i = 0; i < 8; i++) begin
            step(1, 16'(i), 1, 0, 0);
            if (i >= 6) begin
                n_checks++;
                if ({obs_full, obs_af} !== {i == 7, 1'b1})
                    $display("FAIL full_flags_n%0d: got %b want %b", i + 1, {obs_full, obs_af}, {i == 7, 1'b1});
                else n_pass++;
            end
        end
        step(1, 16'h0099, 1, 0, 0);
        n_checks++;
        if ({obs_ack, obs_ovf, obs_din} !== {1'b0, 1'b1, 4'd8})
            $display("FAIL full_overflow: got %h want %h", {obs_ack, obs_ovf, obs_din}, {1'b0, 1'b1, 4'd8});
        else n_pass++;
        step(0, '0, 0, 0, 1);
        n_checks++;
        if ({obs_full, obs_ovf, obs_din} !== {1'b0, 1'b0, 4'd7})
            $display("FAIL full_pop: got %h want %h", {obs_full, obs_ovf, obs_din}, {1'b0, 1'b0, 4'd7});
        else n_pass++;
        drain();
    endtask

    task automatic test_burst_read();
        logic [15:0] d [5];
        for (int i = 0; i < 5; i++) begin
            d[i] = 16'($urandom);
            step(1, d[i], i == 4, 0, 0);
        end
        step(0, '0, 0, 0, 0);
        step(0, '0, 0, 0, 0);
        n_checks++;
        if (obs_pc !== 4'd1) $display("FAIL burst_pkt_before: got %0d want 1", obs_pc);
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ({obs_valid, obs_dout, obs_dlast} !== {1'b1, d[i], i == 4})
                $display("FAIL burst_word%0d: got %h want %h", i, {obs_valid, obs_dout, obs_dlast}, {1'b1, d[i], i == 4});
            else n_pass++;
            step(0, '0, 0, 0, 1);
        end
        n_checks++;
        if ({obs_empty, obs_pc} !== {1'b1, 4'd0})
            $display("FAIL burst_after: got %h want %h", {obs_empty, obs_pc}, {1'b1, 4'd0});
        else n_pass++;
        step(0, '0, 0, 0, 1);
        n_checks++;
        if (obs_unf !== 1'b1) $display("FAIL burst_underflow: got %b want 1", obs_unf);
        else n_pass++;
        drain();
    endtask

    task automatic test_drop_priority();
        step(1, 16'h1111, 0, 0, 0);
        step(1, 16'h2222, 1, 1, 0);
        n_checks++;
        if ({obs_ack, obs_ovf, obs_din, obs_pc} !== {1'b0, 1'b0, 4'd0, 4'd0})
            $display("FAIL wr_drop_same: got %h want 0", {obs_ack, obs_ovf, obs_din, obs_pc});
        else n_pass++;
        step(1, 16'h3333, 1, 0, 0);
        step(0, '0, 0, 0, 0);
        step(0, '0, 0, 0, 0);
        step(1, 16'h4444, 1, 0, 1);
        n_checks++;
        if ({obs_pc, obs_dc} !== {4'd1, 4'd1})
            $display("FAIL commit_pop_same: got %h want %h", {obs_pc, obs_dc}, {4'd1, 4'd1});
        else n_pass++;
        drain();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) step(1, 16'($urandom), i == 2, 0, 0);
        apply_reset();
        n_checks++;
        if ({obs_din, obs_dc, obs_pc, obs_empty, obs_full} !== {4'd0, 4'd0, 4'd0, 1'b1, 1'b0})
            $display("FAIL reset_mid: got %h want %h", {obs_din, obs_dc, obs_pc, obs_empty, obs_full},
                     {4'd0, 4'd0, 4'd0, 1'b1, 1'b0});
        else n_pass++;
        for (int i = 0; i < 3; i++) step(0, '0, 0, 0, 0);
        n_checks++;
        if (obs_empty !== 1'b1) $display("FAIL reset_mid_stays_empty: got %b want 1", obs_empty);
        else n_pass++;
    endtask

    task automatic test_plain_mode();
        logic [15:0] d;
        for (int i = 0; i < 3; i++) begin
            d = 16'($urandom);
            step(1, d, 0, 1, 0);
            n_checks++;
            if (obs_ack !== 1'b1) $display("FAIL plain_ack%0d: got %b want 1", i, obs_ack);
            else n_pass++;
            step(0, '0, 0, 0, 0);
            step(0, '0, 0, 0, 0);
            n_checks++;
            if ({obs_valid, obs_dout, obs_dlast} !== {1'b1, d, 1'b1})
                $display("FAIL plain_word%0d: got %h want %h", i, {obs_valid, obs_dout, obs_dlast}, {1'b1, d, 1'b1});
            else n_pass++;
            step(0, '0, 0, 0, 1);
        end
    endtask

    task automatic test_random(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            step($urandom_range(0, 9) < 6, 16'($urandom), $urandom_range(0, 3) == 0,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1);
            n_checks++;
            if (obs_st !== exp_st()) $display("FAIL rand_status c%0d: got %b want %b", c, obs_st, exp_st());
            else n_pass++;
            if (m_valid) begin
                n_checks++;
                if ({obs_dout, obs_dlast} !== {q_comm[0].d, q_comm[0].l})
                    $display("FAIL rand_dout c%0d: got %h want %h", c, {obs_dout, obs_dlast},
                             {q_comm[0].d, q_comm[0].l});
                else n_pass++;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_checks = 0; n_pass = 0; g_edge = 0;
        sel = 1'b0; m_pmode = 1'b1;
        rst0 = 1'b1; rst1 = 1'b1;
        test_reset();
        test_commit_latency();
        test_drop();
        test_full();
        test_burst_read();
        test_drop_priority();
        test_random(400);
        test_reset_mid();
        sel = 1'b1; m_pmode = 1'b0;
        apply_reset();
        test_plain_mode();
        test_random(300);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
